// File: rtl/sii_l2t_pkg.sv
// Shared types and constants for the SII-to-L2T request scheduler.
package sii_l2t_pkg;

    localparam int NUM_BANKS  = 8;
    localparam int GAP_CYCLES = 3;
    localparam int CRED_W     = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_ADDR = 2'd2,
        ST_GAP  = 2'd3
    } sched_state_e;

endpackage

// File: rtl/sii_l2t_credit_ctr.sv
// One per-bank credit counter: decrements on grant, increments on a dequeue
// return, saturates at MAX_CRED and latches a sticky overflow flag when a
// return arrives with the counter already full.
module sii_l2t_credit_ctr
    import sii_l2t_pkg::*;
#(
    parameter int MAX_CRED = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_l,
    input  logic              i_dec,
    input  logic              i_inc,
    output logic [CRED_W-1:0] o_cnt,
    output logic              o_ovf
);

    localparam logic [CRED_W-1:0] MAX_V = CRED_W'(MAX_CRED);

    logic [CRED_W-1:0] r_cnt;
    logic              r_ovf;

    // Counter update; a simultaneous grant and return cancel out.
    always_ff @(posedge i_clk or negedge i_rst_l) begin
        if (!i_rst_l) begin
            r_cnt <= MAX_V;
            r_ovf <= 1'b0;
        end else if (i_inc && !i_dec) begin
            if (r_cnt == MAX_V) begin
                r_ovf <= 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end else if (i_dec && !i_inc && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_cnt = r_cnt;
    assign o_ovf = r_ovf;

endmodule

// File: rtl/sii_l2t_req_sched.sv
// Two-requester round-robin scheduler that forwards header/address packets
// onto one of eight L2T bank request buses, gated by per-bank IQ and WIB
// credits, with a fixed inter-packet gap.
module sii_l2t_req_sched
    import sii_l2t_pkg::*;
#(
    parameter int IQ_CREDITS  = 4,
    parameter int WIB_CREDITS = 2
) (
    input  logic        iol2clk,
    input  logic        rst_l,
    input  logic        rq0_vld,
    output logic        rq0_rdy,
    input  logic [2:0]  rq0_bank,
    input  logic        rq0_wri,
    input  logic [31:0] rq0_hdr,
    input  logic [31:0] rq0_addr,
    input  logic        rq1_vld,
    output logic        rq1_rdy,
    input  logic [2:0]  rq1_bank,
    input  logic        rq1_wri,
    input  logic [31:0] rq1_hdr,
    input  logic [31:0] rq1_addr,
    output logic [31:0] sii_l2t0_req,
    output logic [31:0] sii_l2t1_req,
    output logic [31:0] sii_l2t2_req,
    output logic [31:0] sii_l2t3_req,
    output logic [31:0] sii_l2t4_req,
    output logic [31:0] sii_l2t5_req,
    output logic [31:0] sii_l2t6_req,
    output logic [31:0] sii_l2t7_req,
    output logic        sii_l2t0_req_vld,
    output logic        sii_l2t1_req_vld,
    output logic        sii_l2t2_req_vld,
    output logic        sii_l2t3_req_vld,
    output logic        sii_l2t4_req_vld,
    output logic        sii_l2t5_req_vld,
    output logic        sii_l2t6_req_vld,
    output logic        sii_l2t7_req_vld,
    input  logic        l2t0_sii_iq_dequeue,
    input  logic        l2t1_sii_iq_dequeue,
    input  logic        l2t2_sii_iq_dequeue,
    input  logic        l2t3_sii_iq_dequeue,
    input  logic        l2t4_sii_iq_dequeue,
    input  logic        l2t5_sii_iq_dequeue,
    input  logic        l2t6_sii_iq_dequeue,
    input  logic        l2t7_sii_iq_dequeue,
    input  logic        l2t0_sii_wib_dequeue,
    input  logic        l2t1_sii_wib_dequeue,
    input  logic        l2t2_sii_wib_dequeue,
    input  logic        l2t3_sii_wib_dequeue,
    input  logic        l2t4_sii_wib_dequeue,
    input  logic        l2t5_sii_wib_dequeue,
    input  logic        l2t6_sii_wib_dequeue,
    input  logic        l2t7_sii_wib_dequeue,
    output logic        credit_err
);

    sched_state_e         r_state, w_state_nxt;
    logic [1:0]           r_gap_cnt;
    logic                 r_last;
    logic [2:0]           r_bank;
    logic [31:0]          r_hdr, r_addr;

    logic [NUM_BANKS-1:0] w_iq_deq, w_wib_deq, w_iq_dec, w_wib_dec;
    logic [NUM_BANKS-1:0] w_iq_ovf, w_wib_ovf;
    logic [CRED_W-1:0]    w_iq_cred  [NUM_BANKS];
    logic [CRED_W-1:0]    w_wib_cred [NUM_BANKS];
    logic                 w_elig0, w_elig1, w_gnt0, w_gnt1, w_gnt;
    logic [2:0]           w_sel_bank;
    logic                 w_sel_wri;
    logic [31:0]          w_req [NUM_BANKS];
    logic [NUM_BANKS-1:0] w_req_vld;

    assign w_iq_deq  = {l2t7_sii_iq_dequeue, l2t6_sii_iq_dequeue, l2t5_sii_iq_dequeue,
                        l2t4_sii_iq_dequeue, l2t3_sii_iq_dequeue, l2t2_sii_iq_dequeue,
                        l2t1_sii_iq_dequeue, l2t0_sii_iq_dequeue};
    assign w_wib_deq = {l2t7_sii_wib_dequeue, l2t6_sii_wib_dequeue, l2t5_sii_wib_dequeue,
                        l2t4_sii_wib_dequeue, l2t3_sii_wib_dequeue, l2t2_sii_wib_dequeue,
                        l2t1_sii_wib_dequeue, l2t0_sii_wib_dequeue};

    // Per-bank credit counters; 8 IQ and 8 WIB.
    for (genvar k = 0; k < NUM_BANKS; k++) begin : g_bank
        sii_l2t_credit_ctr #(.MAX_CRED(IQ_CREDITS)) u_iq (
            .i_clk   (iol2clk),
            .i_rst_l (rst_l),
            .i_dec   (w_iq_dec[k]),
            .i_inc   (w_iq_deq[k]),
            .o_cnt   (w_iq_cred[k]),
            .o_ovf   (w_iq_ovf[k])
        );
        sii_l2t_credit_ctr #(.MAX_CRED(WIB_CREDITS)) u_wib (
            .i_clk   (iol2clk),
            .i_rst_l (rst_l),
            .i_dec   (w_wib_dec[k]),
            .i_inc   (w_wib_deq[k]),
            .o_cnt   (w_wib_cred[k]),
            .o_ovf   (w_wib_ovf[k])
        );
    end

    assign credit_err = |{w_iq_ovf, w_wib_ovf};

    // Eligibility, round-robin grant and next-state decode.
    always_comb begin
        w_elig0     = rq0_vld && (w_iq_cred[rq0_bank] != '0) &&
                      (!rq0_wri || (w_wib_cred[rq0_bank] != '0));
        w_elig1     = rq1_vld && (w_iq_cred[rq1_bank] != '0) &&
                      (!rq1_wri || (w_wib_cred[rq1_bank] != '0));
        w_gnt0      = 1'b0;
        w_gnt1      = 1'b0;
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                // rdy is held low while reset is asserted
                if (rst_l) begin
                    if (w_elig0 && w_elig1) begin
                        w_gnt0 = r_last;
                        w_gnt1 = !r_last;
                    end else begin
                        w_gnt0 = w_elig0;
                        w_gnt1 = w_elig1;
                    end
                end
                if (w_gnt0 || w_gnt1) w_state_nxt = ST_HDR;
            end
            ST_HDR:  w_state_nxt = ST_ADDR;
            ST_ADDR: w_state_nxt = ST_GAP;
            ST_GAP:  if (r_gap_cnt == 2'(GAP_CYCLES - 1)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        w_gnt      = w_gnt0 || w_gnt1;
        w_sel_bank = w_gnt1 ? rq1_bank : rq0_bank;
        w_sel_wri  = w_gnt1 ? rq1_wri : rq0_wri;
        w_iq_dec   = w_gnt ? (NUM_BANKS'(1) << w_sel_bank) : '0;
        w_wib_dec  = (w_gnt && w_sel_wri) ? (NUM_BANKS'(1) << w_sel_bank) : '0;
    end

    assign rq0_rdy = w_gnt0;
    assign rq1_rdy = w_gnt1;

    // FSM state, gap counter and round-robin pointer.
    always_ff @(posedge iol2clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state   <= ST_IDLE;
            r_gap_cnt <= 2'd0;
            r_last    <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= (r_state == ST_GAP) ? r_gap_cnt + 2'd1 : 2'd0;
            if (w_gnt) r_last <= w_gnt1;
        end
    end

    // Packet capture at grant; outputs are qualified by state so no reset needed.
    always_ff @(posedge iol2clk) begin
        if (w_gnt) begin
            r_bank <= w_sel_bank;
            r_hdr  <= w_gnt1 ? rq1_hdr : rq0_hdr;
            r_addr <= w_gnt1 ? rq1_addr : rq0_addr;
        end
    end

    // Drive only the selected bank: header in HDR, address in ADDR.
    always_comb begin
        for (int k = 0; k < NUM_BANKS; k++) w_req[k] = '0;
        w_req_vld = '0;
        if (r_state == ST_HDR) begin
            w_req[r_bank]     = r_hdr;
            w_req_vld[r_bank] = 1'b1;
        end else if (r_state == ST_ADDR) begin
            w_req[r_bank]     = r_addr;
        end
    end

    assign sii_l2t0_req = w_req[0];
    assign sii_l2t1_req = w_req[1];
    assign sii_l2t2_req = w_req[2];
    assign sii_l2t3_req = w_req[3];
    assign sii_l2t4_req = w_req[4];
    assign sii_l2t5_req = w_req[5];
    assign sii_l2t6_req = w_req[6];
    assign sii_l2t7_req = w_req[7];
    assign sii_l2t0_req_vld = w_req_vld[0];
    assign sii_l2t1_req_vld = w_req_vld[1];
    assign sii_l2t2_req_vld = w_req_vld[2];
    assign sii_l2t3_req_vld = w_req_vld[3];
    assign sii_l2t4_req_vld = w_req_vld[4];
    assign sii_l2t5_req_vld = w_req_vld[5];
    assign sii_l2t6_req_vld = w_req_vld[6];
    assign sii_l2t7_req_vld = w_req_vld[7];

endmodule

// File: tb/tb_sii_l2t_req_sched.sv
// Bench for sii_l2t_req_sched: directed scenarios with literal expectations,
// plus a cycle-by-cycle compare against a packet-level model of the scheduler.
module tb_sii_l2t_req_sched;

    localparam int IQC  = 4;
    localparam int WIBC = 2;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        rq0_vld = 1'b0, rq0_wri = 1'b0, rq0_rdy;
    logic [2:0]  rq0_bank = '0;
    logic [31:0] rq0_hdr = '0, rq0_addr = '0;
    logic        rq1_vld = 1'b0, rq1_wri = 1'b0, rq1_rdy;
    logic [2:0]  rq1_bank = '0;
    logic [31:0] rq1_hdr = '0, rq1_addr = '0;
    logic [31:0] req [8];
    logic [7:0]  req_vld;
    logic [7:0]  iq_deq = '0, wib_deq = '0;
    logic        credit_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sii_l2t_req_sched #(.IQ_CREDITS(IQC), .WIB_CREDITS(WIBC)) dut (
        .iol2clk(clk), .rst_l(rst_l),
        .rq0_vld(rq0_vld), .rq0_rdy(rq0_rdy), .rq0_bank(rq0_bank), .rq0_wri(rq0_wri),
        .rq0_hdr(rq0_hdr), .rq0_addr(rq0_addr),
        .rq1_vld(rq1_vld), .rq1_rdy(rq1_rdy), .rq1_bank(rq1_bank), .rq1_wri(rq1_wri),
        .rq1_hdr(rq1_hdr), .rq1_addr(rq1_addr),
        .sii_l2t0_req(req[0]), .sii_l2t1_req(req[1]), .sii_l2t2_req(req[2]), .sii_l2t3_req(req[3]),
        .sii_l2t4_req(req[4]), .sii_l2t5_req(req[5]), .sii_l2t6_req(req[6]), .sii_l2t7_req(req[7]),
        .sii_l2t0_req_vld(req_vld[0]), .sii_l2t1_req_vld(req_vld[1]),
        .sii_l2t2_req_vld(req_vld[2]), .sii_l2t3_req_vld(req_vld[3]),
        .sii_l2t4_req_vld(req_vld[4]), .sii_l2t5_req_vld(req_vld[5]),
        .sii_l2t6_req_vld(req_vld[6]), .sii_l2t7_req_vld(req_vld[7]),
        .l2t0_sii_iq_dequeue(iq_deq[0]), .l2t1_sii_iq_dequeue(iq_deq[1]),
        .l2t2_sii_iq_dequeue(iq_deq[2]), .l2t3_sii_iq_dequeue(iq_deq[3]),
        .l2t4_sii_iq_dequeue(iq_deq[4]), .l2t5_sii_iq_dequeue(iq_deq[5]),
        .l2t6_sii_iq_dequeue(iq_deq[6]), .l2t7_sii_iq_dequeue(iq_deq[7]),
        .l2t0_sii_wib_dequeue(wib_deq[0]), .l2t1_sii_wib_dequeue(wib_deq[1]),
        .l2t2_sii_wib_dequeue(wib_deq[2]), .l2t3_sii_wib_dequeue(wib_deq[3]),
        .l2t4_sii_wib_dequeue(wib_deq[4]), .l2t5_sii_wib_dequeue(wib_deq[5]),
        .l2t6_sii_wib_dequeue(wib_deq[6]), .l2t7_sii_wib_dequeue(wib_deq[7]),
        .credit_err(credit_err)
    );

    // ---------------- packet-level model ----------------
    // m_since counts cycles since the last grant (1 = header cycle, 2 = address
    // cycle); a new grant is permitted once it reaches 6.
    int          m_iq [8];
    int          m_wib [8];
    bit          m_err;
    int          m_since;
    bit          m_last;
    int          m_bank;
    logic [31:0] m_hdr, m_addr;

    function automatic bit m_elig(logic vld, logic [2:0] bank, logic wri);
        return vld && (m_iq[bank] > 0) && (!wri || (m_wib[bank] > 0));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 8; k++) begin
            m_iq[k]  = IQC;
            m_wib[k] = WIBC;
        end
        m_err   = 1'b0;
        m_since = 6;
        m_last  = 1'b1;
        m_bank  = 0;
    endtask

    // Compare every cycle at the falling edge, then advance the model.
    always @(negedge clk) begin : cmp
        logic [31:0] e_req [8];
        logic [7:0]  e_vld;
        bit          g0, g1, el0, el1, bad;
        bit [7:0]    dq_i, dq_w;
        int          b;
        g0 = 1'b0; g1 = 1'b0;
        e_vld = '0;
        for (int k = 0; k < 8; k++) e_req[k] = '0;
        if (!rst_l) begin
            m_reset();
        end else begin
            if (m_since == 1) begin
                e_req[m_bank] = m_hdr;
                e_vld[m_bank] = 1'b1;
            end else if (m_since == 2) begin
                e_req[m_bank] = m_addr;
            end
            if (m_since >= 6) begin
                el0 = m_elig(rq0_vld, rq0_bank, rq0_wri);
                el1 = m_elig(rq1_vld, rq1_bank, rq1_wri);
                if (el0 && el1) begin
                    g0 = m_last;
                    g1 = !m_last;
                end else begin
                    g0 = el0;
                    g1 = el1;
                end
            end
        end
        n_tests++;
        bad = 1'b0;
        if ({rq0_rdy, rq1_rdy, credit_err, req_vld} !== {g0, g1, m_err, e_vld}) begin
            $display("FAIL model_ctl t=%0t got rdy0/rdy1/err/vld=%b required %b", $time,
                     {rq0_rdy, rq1_rdy, credit_err, req_vld}, {g0, g1, m_err, e_vld});
            bad = 1'b1;
        end
        for (int k = 0; k < 8; k++) begin
            if (!bad && (req[k] !== e_req[k])) begin
                $display("FAIL model_req%0d t=%0t got %h required %h", k, $time, req[k], e_req[k]);
                bad = 1'b1;
            end
        end
        if (bad) n_fail++;
        if (rst_l) begin
            dq_i = '0;
            dq_w = '0;
            if (g0 || g1) begin
                b      = g1 ? int'(rq1_bank) : int'(rq0_bank);
                m_bank = b;
                m_hdr  = g1 ? rq1_hdr : rq0_hdr;
                m_addr = g1 ? rq1_addr : rq0_addr;
                dq_i[b] = 1'b1;
                if (g1 ? rq1_wri : rq0_wri) dq_w[b] = 1'b1;
                m_last  = g1;
                m_since = 1;
            end else if (m_since < 1000) begin
                m_since++;
            end
            for (int k = 0; k < 8; k++) begin
                if (iq_deq[k] && !dq_i[k] && m_iq[k] == IQC) m_err = 1'b1;
                else m_iq[k] = m_iq[k] + int'(iq_deq[k]) - int'(dq_i[k]);
                if (wib_deq[k] && !dq_w[k] && m_wib[k] == WIBC) m_err = 1'b1;
                else m_wib[k] = m_wib[k] + int'(wib_deq[k]) - int'(dq_w[k]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %h required %h", name, $time, act, exp);
        end
    endtask

    task automatic do_reset();
        rq0_vld = 1'b0;
        rq1_vld = 1'b0;
        iq_deq  = '0;
        wib_deq = '0;
        rst_l   = 1'b0;
        tick();
        tick();
        rst_l   = 1'b1;
    endtask

    initial begin
        // Reset state: rdy stays low even with a valid request pending.
        tick();
        rq0_vld = 1'b1; rq0_bank = 3'd3;
        #1;
        chk("rst_rdy0", rq0_rdy, 0);
        chk("rst_err", credit_err, 0);
        chk("rst_vld", req_vld, 0);
        chk("rst_req3", req[3], 0);
        tick();
        do_reset();

        // Single packet to bank 3, then gap and next grant at cycle 6.
        rq0_vld = 1'b1; rq0_bank = 3'd3; rq0_wri = 1'b0;
        rq0_hdr = 32'h1234_5678; rq0_addr = 32'hDEAD_BEEF;
        #1 chk("t1_rdy0_c0", rq0_rdy, 1);
        tick();
        rq0_vld = 1'b0; rq0_hdr = 32'hFFFF_FFFF; rq0_addr = 32'h0;
        #1 chk("t1_req3_c1", req[3], 32'h1234_5678);
        chk("t1_vld_c1", req_vld, 8'h08);
        tick();
        #1 chk("t1_req3_c2", req[3], 32'hDEAD_BEEF);
        chk("t1_vld_c2", req_vld, 8'h00);
        for (int c = 3; c <= 6; c++) begin
            tick();
            rq0_vld = 1'b1; rq0_bank = 3'd1; rq0_hdr = 32'hA0A0_0001; rq0_addr = 32'hB0B0_0001;
            #1;
            chk($sformatf("t1_req3_c%0d", c), req[3], 0);
            chk($sformatf("t1_rdy0_c%0d", c), rq0_rdy, (c == 6) ? 1 : 0);
        end
        tick();
        rq0_vld = 1'b0;
        #1 chk("t1_req1_c7", req[1], 32'hA0A0_0001);
        tick();
        iq_deq[3] = 1'b1;
        tick();
        iq_deq = '0;
        do_reset();

        // Both requesters to bank 0: alternating grants every 6 cycles.
        rq0_vld = 1'b1; rq0_bank = 3'd0; rq0_wri = 1'b0; rq0_hdr = 32'h0000_0A00; rq0_addr = 32'h0000_0A01;
        rq1_vld = 1'b1; rq1_bank = 3'd0; rq1_wri = 1'b0; rq1_hdr = 32'h0000_0B00; rq1_addr = 32'h0000_0B01;
        for (int c = 0; c <= 18; c++) begin
            iq_deq[0] = ((c % 6) == 1);
            #1;
            chk($sformatf("rr_rdy0_c%0d", c), rq0_rdy, ((c % 12) == 0) ? 1 : 0);
            chk($sformatf("rr_rdy1_c%0d", c), rq1_rdy, ((c % 12) == 6) ? 1 : 0);
            tick();
        end
        do_reset();

        // IQ credit exhaustion on bank 5, released by one dequeue.
        rq0_vld = 1'b1; rq0_bank = 3'd5; rq0_wri = 1'b0; rq0_hdr = 32'h5555_0000; rq0_addr = 32'h5555_0001;
        for (int c = 0; c <= 31; c++) begin
            iq_deq[5] = (c == 30);
            #1;
            chk($sformatf("iq_rdy0_c%0d", c), rq0_rdy,
                (c == 0 || c == 6 || c == 12 || c == 18 || c == 31) ? 1 : 0);
            tick();
        end
        do_reset();

        // WIB exhaustion on bank 2; a plain request from rq1 still gets through.
        rq0_vld = 1'b1; rq0_bank = 3'd2; rq0_wri = 1'b1; rq0_hdr = 32'h2222_0000; rq0_addr = 32'h2222_0001;
        rq1_bank = 3'd2; rq1_wri = 1'b0; rq1_hdr = 32'h2222_1000; rq1_addr = 32'h2222_1001;
        for (int c = 0; c <= 20; c++) begin
            rq1_vld = (c == 12);
            #1;
            chk($sformatf("wib_rdy0_c%0d", c), rq0_rdy, (c == 0 || c == 6) ? 1 : 0);
            chk($sformatf("wib_rdy1_c%0d", c), rq1_rdy, (c == 12) ? 1 : 0);
            tick();
        end
        do_reset();

        // Overflowing dequeue on bank 7, then verify the count stayed at 4.
        iq_deq[7] = 1'b1;
        #1 chk("ovf_err_c0", credit_err, 0);
        tick();
        iq_deq = '0;
        #1 chk("ovf_err_c1", credit_err, 1);
        rq1_vld = 1'b1; rq1_bank = 3'd7; rq1_wri = 1'b0; rq1_hdr = 32'h7777_0000; rq1_addr = 32'h7777_0001;
        for (int c = 0; c <= 33; c++) begin
            iq_deq[7] = (c == 6);
            #1;
            chk($sformatf("ovf_rdy1_c%0d", c), rq1_rdy,
                (c == 0 || c == 6 || c == 12 || c == 18 || c == 24) ? 1 : 0);
            tick();
        end
        rq1_vld = 1'b0;
        #1 chk("ovf_err_sticky", credit_err, 1);
        do_reset();

        // Reset during the address cycle, then a clean repeat with full credits.
        rq0_vld = 1'b1; rq0_bank = 3'd3; rq0_wri = 1'b1; rq0_hdr = 32'h1234_5678; rq0_addr = 32'hDEAD_BEEF;
        #1 chk("ar_rdy0_c0", rq0_rdy, 1);
        tick();
        tick();
        #1 chk("ar_req3_c2", req[3], 32'hDEAD_BEEF);
        #1 rst_l = 1'b0;
        #1;
        chk("ar_req3_rst", req[3], 0);
        chk("ar_vld_rst", req_vld, 0);
        chk("ar_rdy0_rst", rq0_rdy, 0);
        tick();
        rst_l = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            #1;
            chk($sformatf("ar_rdy0_c%0d", c), rq0_rdy, (c == 0 || c == 6) ? 1 : 0);
            if (c == 1) chk("ar_hdr_c1", req[3], 32'h1234_5678);
            if (c == 2) chk("ar_addr_c2", req[3], 32'hDEAD_BEEF);
            tick();
        end
        rq0_vld = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sii_l2t_req_sched.md
SII_L2T_REQ_SCHED -- requirements
Module: sii_l2t_req_sched

Interface
REQ-001 SHALL have parameter IQ_CREDITS, default 4, meaning per-bank L2T input-queue depth (range 1..7).
REQ-002 SHALL have parameter WIB_CREDITS, default 2, meaning per-bank I/O write-buffer entries (range 1..7).
REQ-003 SHALL have port iol2clk, input, 1, the single clock; all state is on its rising edge.
REQ-004 SHALL have port rst_l, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have ports rq0_vld and rq1_vld, input, 1 each, requester 0/1 valid.
REQ-006 SHALL have ports rq0_rdy and rq1_rdy, output, 1 each, requester accept; a transfer occurs when vld and rdy are both high.
REQ-007 SHALL have ports rqN_bank, input, 3 each, target L2 bank 0..7.
REQ-008 SHALL have ports rqN_wri, input, 1 each; high means a write-invalidate request, which also needs a WIB credit.
REQ-009 SHALL have ports rqN_hdr and rqN_addr, input, 32 each, header word and address[31:0] word.
REQ-010 SHALL have ports sii_l2tK_req, output, 32, for K = 0..7, the per-bank request bus.
REQ-011 SHALL have ports sii_l2tK_req_vld, output, 1, for K = 0..7, marking the header cycle.
REQ-012 SHALL have ports l2tK_sii_iq_dequeue and l2tK_sii_wib_dequeue, input, 1 each, for K = 0..7, single-cycle credit returns.
REQ-013 SHALL have port credit_err, output, 1, sticky error flag.

Function
REQ-014 SHALL implement FSM IDLE -> HDR -> ADDR -> GAP -> IDLE.
- GAP lasts exactly 3 cycles, counted by a 2-bit counter.
REQ-015 In IDLE, a requester SHALL be eligible when all of these hold:
- vld is high;
- iq_cred[bank] > 0;
- if wri is high, wib_cred[bank] > 0.
REQ-016 In IDLE, the scheduler SHALL grant one eligible requester per cycle.
- Arbitration is round-robin; the last-granted pointer resets to 1, so requester 0 wins the first tie.
- rdy is asserted combinationally only to the granted requester, and only in IDLE.
REQ-017 On grant, the scheduler SHALL latch bank, hdr and addr, and decrement iq_cred[bank].
- If wri is high, it also decrements wib_cred[bank].
REQ-018 In HDR (grant + 1 cycle), sii_l2t[bank]_req SHALL equal the latched hdr, with sii_l2t[bank]_req_vld = 1.
REQ-019 In ADDR (grant + 2 cycles), sii_l2t[bank]_req SHALL equal the latched addr, with req_vld = 0.
REQ-020 The output drive rules SHALL be:
- in GAP and IDLE, all req buses are 0 and all req_vld are 0;
- non-selected banks are always 0.
REQ-021 Back-to-back packets SHALL be spaced so that the next grant occurs no earlier than cycle 6 after the previous grant.
- The next header therefore appears no earlier than cycle 7.
REQ-022 A dequeue pulse SHALL increment the matching counter by 1.
- A grant decrement and a dequeue on the same bank in the same cycle leave the counter unchanged.
REQ-023 A dequeue when the counter is at its maximum SHALL leave the counter unchanged and set credit_err.
- credit_err stays set until reset.
REQ-024 Dequeue inputs SHALL be honoured in every FSM state, for all 8 banks concurrently.
REQ-025 rqN_* inputs SHALL be sampled only at grant; changes while not granted have no effect.

Reset
REQ-026 Asserting rst_l low SHALL asynchronously force the following, even mid-packet:
- FSM = IDLE, GAP counter = 0, RR pointer = 1;
- iq_cred = IQ_CREDITS and wib_cred = WIB_CREDITS for all banks;
- credit_err = 0;
- all req buses, req_vld and rdy = 0.
REQ-027 A packet interrupted by reset SHALL NOT resume, and its credits SHALL be restored to full.

Structure
REQ-028 A shared package sii_l2t_pkg SHALL hold:
- the FSM state enum;
- the NUM_BANKS = 8 constant;
- the GAP_CYCLES = 3 constant;
- the credit-counter width of 3.
REQ-029 A sub-module sii_l2t_credit_ctr SHALL implement one up/down saturating credit counter with overflow flag.
- It is instantiated 16 times: 8 IQ counters and 8 WIB counters.

Verification
REQ-030 Reset, then rq0 with bank = 3, hdr = 0x1234_5678, addr = 0xDEAD_BEEF and rdy high at cycle 0 -> cycle 1: sii_l2t3_req = 0x12345678 with vld = 1; cycle 2: sii_l2t3_req = 0xDEADBEEF with vld = 0; cycles 3-5: all outputs 0.
REQ-031 rq0 and rq1 both continuously valid to bank 0 -> grants alternate rq0, rq1, rq0, ..., with grants at cycles 0, 6, 12, ...
REQ-032 Five requests to bank 5 with no dequeue -> four are granted, the fifth stalls with rdy low; one l2t5_sii_iq_dequeue pulse -> the fifth is granted at the next IDLE.
REQ-033 Three WRI requests to bank 2 with wib never dequeued -> two are granted, the third stalls; meanwhile a non-WRI request to bank 2 from the other requester is granted.
REQ-034 l2t7_sii_iq_dequeue pulsed with bank 7 at full credit -> credit_err = 1, and iq_cred[7] stays 4.
REQ-035 rst_l asserted during ADDR -> outputs 0 immediately (asynchronously); after release, the credits for that bank are back at 4/2 and the next request behaves as in REQ-030.
